// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: mispredict detection, registered fetch redirect,
// wrong-path squash window, and a training-update FIFO drained into the predictor.
module branch_resolve_unit #(
  parameter int DEPTH         = 4,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic [29:0] br_pc,
  input  logic        br_is_cond,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        ext_flush,
  output logic        exe_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic [8:0]  upd_index,
  output logic        upd_taken,
  input  logic        upd_ready,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  state_t        state_r;
  logic [2:0]    sq_cnt_r;
  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_r;
  logic          valid_r;
  logic          redirect_valid_r;
  logic [31:0]   redirect_pc_r;
  logic [31:0]   stat_branches_r;
  logic [31:0]   stat_mispredicts_r;

  logic          accept_s;
  logic          mispredict_s;
  logic          push_s;
  logic          pop_s;
  logic [AW:0]   count_next_s;

  // Acceptance, mispredict detection and FIFO occupancy update
  always_comb begin
    accept_s     = br_valid & ~full_r & ~ext_flush & (state_r == RUN);
    mispredict_s = (pred_taken != br_taken) |
                   (pred_taken & br_taken & (pred_target != br_target));
    push_s       = accept_s & br_is_cond;
    pop_s        = valid_r & upd_ready;
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + {{AW{1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{AW{1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Squash-window FSM and registered redirect pulse; flush only cancels the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= RUN;
      sq_cnt_r         <= 3'd0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
    end else begin
      redirect_valid_r <= accept_s & mispredict_s;
      if (accept_s & mispredict_s) begin
        redirect_pc_r <= br_taken ? br_target : {br_pc + 30'd1, 2'b00};
      end
      if (ext_flush) begin
        state_r  <= RUN;
        sq_cnt_r <= 3'd0;
      end else begin
        case (state_r)
          RUN: begin
            if (accept_s & mispredict_s) begin
              state_r  <= SQUASH;
              sq_cnt_r <= 3'(SQUASH_CYCLES);
            end
          end
          SQUASH: begin
            if (sq_cnt_r == 3'd1) begin
              state_r  <= RUN;
              sq_cnt_r <= 3'd0;
            end else begin
              sq_cnt_r <= sq_cnt_r - 3'd1;
            end
          end
          default: begin
            state_r  <= RUN;
            sq_cnt_r <= 3'd0;
          end
        endcase
      end
    end
  end

  // Training FIFO storage, pointers and registered full/valid flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 10'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {br_pc[8:0], br_taken};
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == (AW+1)'(DEPTH));
      valid_r <= (count_next_s != '0);
    end
  end

  // Wrapping hit/miss statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_r    <= 32'd0;
      stat_mispredicts_r <= 32'd0;
    end else begin
      if (accept_s & br_is_cond) stat_branches_r <= stat_branches_r + 32'd1;
      if (accept_s & mispredict_s) stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
    end
  end

  assign exe_stall        = full_r;
  assign upd_valid        = valid_r;
  assign upd_index        = mem_r[rd_ptr_r][9:1];
  assign upd_taken        = mem_r[rd_ptr_r][0];
  assign redirect_valid   = redirect_valid_r;
  assign redirect_pc      = redirect_pc_r;
  assign stat_branches    = stat_branches_r;
  assign stat_mispredicts = stat_mispredicts_r;

endmodule
